// File: rtl/opamp_sar_reader_pkg.sv
// Shared types and constants for the op-amp output SAR conversion controller.
package opamp_sar_reader_pkg;

  typedef enum logic [1:0] {StIdle, StAcq, StConv, StDone} state_e;

  localparam int unsigned DefWidth     = 12;
  localparam int unsigned DefAcqCyc    = 4;
  localparam int unsigned DefSettleCyc = 2;
  localparam int unsigned TimerW       = 16;

  // Edges from the start-sampling edge to the edge that raises res_valid.
  function automatic int unsigned conv_latency(input int unsigned width,
                                               input int unsigned acq_cyc,
                                               input int unsigned settle_cyc);
    return acq_cyc + width * settle_cyc + 1;
  endfunction

endpackage

// File: rtl/opamp_sar_reader_settle_timer.sv
// Loadable down-counter shared by acquisition and per-bit settling; pulses expire
// during the final counted cycle.
module sar_settle_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  output logic            expire
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CntW'(1));

endmodule

// File: rtl/opamp_sar_reader.sv
// SAR conversion controller: sample/hold and DAC trial sequencing, comparator-driven
// bit decisions, and a valid/ready result port with sticky overrun.
module opamp_sar_reader
  import opamp_sar_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned ACQ_CYC    = DefAcqCyc,
  parameter int unsigned SETTLE_CYC = DefSettleCyc
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   trial_q, trial_d;
  logic               timer_load, timer_exp;
  logic [TimerW-1:0]  timer_val;

  logic               sample_d, busy_d, res_valid_d, overrun_d;
  logic [WIDTH-1:0]   dac_d, res_data_d;
  logic               done, xfer;

  sar_settle_timer #(
    .CntW(TimerW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .load_val(timer_val),
    .expire  (timer_exp)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    trial_d    = trial_q;
    timer_load = 1'b0;
    timer_val  = TimerW'(SETTLE_CYC);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StAcq;
          idx_d      = IdxW'(WIDTH - 1);
          trial_d    = '0;
          timer_load = 1'b1;
          timer_val  = TimerW'(ACQ_CYC);
        end
      end
      StAcq: begin
        if (abort) begin
          state_d = StIdle;
        end else if (timer_exp) begin
          state_d    = StConv;
          timer_load = 1'b1;
        end
      end
      StConv: begin
        if (abort) begin
          state_d = StIdle;
        end else if (timer_exp) begin
          trial_d[idx_q] = cmp;
          if (idx_q == '0) begin
            state_d = StDone;
          end else begin
            idx_d      = idx_q - 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  always_comb begin
    sample_d = (state_d == StAcq);
    busy_d   = (state_d != StIdle);
    dac_d    = (state_d == StConv) ? (trial_d | (One << idx_d)) : '0;
  end

  assign done = (state_q == StDone);
  assign xfer = res_valid & res_ready;

  always_comb begin
    res_data_d  = done ? trial_q : res_data;
    res_valid_d = done | (res_valid & ~res_ready);
    overrun_d   = overrun;
    if (done && res_valid && !res_ready) begin
      overrun_d = 1'b1;
    end else if (xfer && !done) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      trial_q   <= '0;
      sample    <= 1'b0;
      busy      <= 1'b0;
      dac_code  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      trial_q   <= trial_d;
      sample    <= sample_d;
      busy      <= busy_d;
      dac_code  <= dac_d;
      res_data  <= res_data_d;
      res_valid <= res_valid_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_opamp_sar_reader.sv
// Directed and randomized checks of opamp_sar_reader against an ideal-SAR model
// driven by an ideal comparator (cmp = Vin >= dac_code).
module tb_opamp_sar_reader;

  localparam int unsigned W = 4;
  localparam int unsigned A = 2;
  localparam int unsigned S = 1;
  localparam int L = A + W * S + 1;  // edges from start edge to res_valid edge
  localparam int P = A + W * S + 2;  // back-to-back conversion period

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         res_ready = 1'b0;
  logic         cmp, sample, busy, res_valid, overrun;
  logic [W-1:0] dac_code, res_data;
  int           vin = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int results, first_n, second_n;
  logic seen;

  assign cmp = (vin >= int'(dac_code));

  opamp_sar_reader #(
    .WIDTH     (W),
    .ACQ_CYC   (A),
    .SETTLE_CYC(S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cmp      (cmp),
    .sample   (sample),
    .dac_code (dac_code),
    .busy     (busy),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal SAR: bits above i already equal Vin's bits; bit i is the trial bit.
  function automatic int ref_trial(input int v, input int i);
    return ((v >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction

  function automatic int ref_result(input int v);
    if (v < 0) return 0;
    if (v > (1 << W) - 1) return (1 << W) - 1;
    return v;
  endfunction

  // Entered and left just after a falling edge; ends on the cycle res_valid rises.
  task automatic convert(input int v, input bit ready_at_done);
    vin   = v;
    start = 1'b1;
    for (int n = 1; n <= L + 1; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n <= A) begin
        check("acq_sample", sample, 1);
        check("acq_dac", dac_code, 0);
        check("acq_busy", busy, 1);
      end else if (n <= A + W * S) begin
        check("conv_dac", dac_code, ref_trial(v, W - 1 - (n - A - 1) / S));
        check("conv_sample", sample, 0);
        check("conv_busy", busy, 1);
      end else if (n == L) begin
        check("done_dac", dac_code, 0);
        check("done_busy", busy, 1);
        if (ready_at_done) res_ready = 1'b1;
      end else begin
        check("res_valid", res_valid, 1);
        check("res_data", res_data, ref_result(v));
        check("res_busy", busy, 0);
      end
    end
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    check("xfer_valid", res_valid, 0);
    check("xfer_overrun", overrun, 0);
    res_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sample"}, sample, 0);
    check({tag, "_dac"}, dac_code, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, res_data, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single conversion, Vin=11: trials 8, 12, 10, 11
    convert(11, 1'b0);
    check("single_hex_b", res_data, 4'hB);
    accept();

    // Endpoints
    convert(0, 1'b0);
    accept();
    convert(15, 1'b0);
    accept();
    convert(8, 1'b0);
    accept();

    // Random codes with random idle gaps
    repeat (8) begin
      convert(int'($urandom_range(0, 15)), 1'b0);
      accept();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Abort while bit 2 is on trial
    vin   = 13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (A + S) @(negedge clk);
    check("abort_pre_dac", dac_code, ref_trial(13, 2));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_sample", sample, 0);
    check("abort_dac", dac_code, 0);
    check("abort_busy", busy, 0);
    seen = 1'b0;
    repeat (2 * P) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    convert(6, 1'b0);
    accept();

    // Overrun: second result overwrites an unaccepted first one
    convert(5, 1'b0);
    check("ovr_first", overrun, 0);
    convert(9, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_data", res_data, 9);
    accept();

    // DONE coincides with transfer of the previous result
    convert(3, 1'b0);
    convert(12, 1'b1);
    check("same_cycle_overrun", overrun, 0);
    accept();

    // Asynchronous reset mid-conversion with a result pending
    convert(2, 1'b0);
    vin   = 7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (A + 1) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_idle_busy", busy, 0);
    check("rst_idle_valid", res_valid, 0);
    convert(10, 1'b0);
    accept();

    // start pulses while busy are ignored
    res_ready = 1'b1;
    results   = 0;
    vin       = 9;
    start     = 1'b1;
    for (int n = 1; n <= 3 * P; n++) begin
      @(negedge clk);
      if (res_valid) begin
        results++;
        check("gate_data", res_data, 9);
      end
      if (n < L) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
    end
    check("gate_count", results, 1);

    // start held high: one conversion per period
    results  = 0;
    first_n  = -1;
    second_n = -1;
    vin      = 4;
    start    = 1'b1;
    for (int n = 1; n <= 3 * P; n++) begin
      @(negedge clk);
      if (res_valid) begin
        results++;
        if (first_n < 0) first_n = n;
        else second_n = n;
      end
      if (n == 2 * P) start = 1'b0;
    end
    check("b2b_count", results, 2);
    check("b2b_first", first_n, L + 1);
    check("b2b_gap", second_n - first_n, P);
    res_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
